riscv_csr_state: RTL and testbench

Machine-mode CSR register file and trap-state holder in the execute/state stage of the MPSoC-RISCV core. It answers the execute-stage CSR port:
- accepts the 12-bit CSR address, write value and write enable;
- returns the current CSR value combinationally on the same cycle.

It also maintains the cycle and instret counters, records exception entry and mret exit, and exports mtvec, mepc and the interrupt-enable bit to fetch and control.

---
 rtl/riscv_mpsoc_pkg.sv | 39 +++
 rtl/riscv_csr_counter.sv | 25 ++
 rtl/riscv_csr_state.sv | 155 +++++++++++++++
 tb/tb_riscv_csr_state.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mpsoc_pkg.sv
// Shared constants for the MPSoC-RISCV core: CSR addresses, mstatus fields,
// xlen codes and misa extension bits.
package riscv_mpsoc_pkg;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MISA      = 12'h301;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_CYCLE     = 12'hC00;
   localparam logic [11:0] CSR_INSTRET   = 12'hC02;
   localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
   localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
   localparam logic [11:0] CSR_MVENDORID = 12'hF11;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   localparam logic [1:0] XLEN_RV32I = 2'd1;
   localparam logic [1:0] XLEN_RV64I = 2'd2;

   localparam int MISA_C = 2;
   localparam int MISA_I = 8;

   // Address space 0xC00-0xFFF is read-only by encoding.
   function automatic logic csr_addr_read_only(input logic [11:0] addr);
      return addr[11:10] == 2'b11;
   endfunction

endpackage

// File: rtl/riscv_csr_counter.sv
// 64-bit performance counter with independent lo/hi write strobes; a write
// to either half suppresses the increment for that cycle.
module riscv_csr_counter (
   input  logic        clk,
   input  logic        rstn,
   input  logic        inc,
   input  logic        wr_lo,
   input  logic        wr_hi,
   input  logic [31:0] wdata_lo,
   input  logic [31:0] wdata_hi,
   output logic [63:0] count
);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         count <= '0;
      end else if (wr_lo || wr_hi) begin
         if (wr_lo) count[31:0]  <= wdata_lo;
         if (wr_hi) count[63:32] <= wdata_hi;
      end else if (inc) begin
         count <= count + 64'd1;
      end
   end

endmodule

// File: rtl/riscv_csr_state.sv
// Machine-mode CSR file and trap state: combinational CSR read port,
// registered writes, cycle/instret counters, exception entry and mret exit.
module riscv_csr_state
   import riscv_mpsoc_pkg::*;
#(
   parameter int              XLEN        = 64,
   parameter int              HAS_RVC     = 1,
   parameter int              HARTID      = 0,
   parameter logic [XLEN-1:0] MTVEC_RESET = 'h100
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            ex_stall,
   input  logic [11:0]     ex_csr_reg,
   input  logic            ex_csr_we,
   input  logic [XLEN-1:0] ex_csr_wval,
   output logic [XLEN-1:0] st_csr_rval,
   output logic            st_csr_illegal,
   output logic [1:0]      st_xlen,
   input  logic            wb_retire,
   input  logic            ex_exception,
   input  logic [XLEN-1:0] ex_cause,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_tval,
   input  logic            ex_mret,
   output logic [XLEN-1:0] st_mtvec,
   output logic [XLEN-1:0] st_mepc,
   output logic            st_mie
);

   localparam logic [XLEN-1:0] EPC_MASK   = (HAS_RVC != 0) ? ~XLEN'(1) : ~XLEN'(3);
   localparam logic [XLEN-1:0] MTVEC_MASK = ~XLEN'(3);

   logic            mie, mpie;
   logic [XLEN-1:0] mtvec, mscratch, mepc, mcause, mtval;
   logic [63:0]     mcycle, minstret;
   logic [63:0]     wval64;
   logic            unimpl;
   logic            exc_take, mret_take, csr_wen;
   logic            cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;
   logic [31:0]     wdata_hi;

   always_comb begin
      st_csr_rval = '0;
      unimpl      = 1'b0;
      case (ex_csr_reg)
         CSR_MSTATUS: begin
            st_csr_rval[MSTATUS_MIE]                   = mie;
            st_csr_rval[MSTATUS_MPIE]                  = mpie;
            st_csr_rval[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
         end
         CSR_MISA: begin
            st_csr_rval[XLEN-1 -: 2] = (XLEN == 64) ? 2'b10 : 2'b01;
            st_csr_rval[MISA_I]      = 1'b1;
            st_csr_rval[MISA_C]      = (HAS_RVC != 0);
         end
         CSR_MTVEC:                 st_csr_rval = mtvec;
         CSR_MSCRATCH:              st_csr_rval = mscratch;
         CSR_MEPC:                  st_csr_rval = mepc;
         CSR_MCAUSE:                st_csr_rval = mcause;
         CSR_MTVAL:                 st_csr_rval = mtval;
         CSR_MCYCLE, CSR_CYCLE:     st_csr_rval = mcycle[XLEN-1:0];
         CSR_MINSTRET, CSR_INSTRET: st_csr_rval = minstret[XLEN-1:0];
         CSR_MCYCLEH, CSR_CYCLEH: begin
            if (XLEN == 32) st_csr_rval = XLEN'(mcycle[63:32]);
            else            unimpl      = 1'b1;
         end
         CSR_MINSTRETH, CSR_INSTRETH: begin
            if (XLEN == 32) st_csr_rval = XLEN'(minstret[63:32]);
            else            unimpl      = 1'b1;
         end
         CSR_MVENDORID:             st_csr_rval = '0;
         CSR_MHARTID:               st_csr_rval = XLEN'(HARTID);
         default:                   unimpl      = 1'b1;
      endcase
   end

   assign st_csr_illegal = unimpl || (ex_csr_we && csr_addr_read_only(ex_csr_reg));

   // Priority: exception, then mret, then CSR write; losers are dropped.
   assign exc_take  = ex_exception && !ex_stall;
   assign mret_take = ex_mret && !ex_stall && !ex_exception;
   assign csr_wen   = ex_csr_we && !ex_stall && !st_csr_illegal && !ex_exception && !ex_mret;

   assign wval64    = 64'(ex_csr_wval);
   assign wdata_hi  = (XLEN == 64) ? wval64[63:32] : wval64[31:0];
   assign cyc_wr_lo = csr_wen && (ex_csr_reg == CSR_MCYCLE);
   assign ins_wr_lo = csr_wen && (ex_csr_reg == CSR_MINSTRET);
   assign cyc_wr_hi = csr_wen && ((XLEN == 64) ? (ex_csr_reg == CSR_MCYCLE)
                                               : (ex_csr_reg == CSR_MCYCLEH));
   assign ins_wr_hi = csr_wen && ((XLEN == 64) ? (ex_csr_reg == CSR_MINSTRET)
                                               : (ex_csr_reg == CSR_MINSTRETH));

   riscv_csr_counter u_mcycle (
      .clk      (clk),
      .rstn     (rstn),
      .inc      (1'b1),
      .wr_lo    (cyc_wr_lo),
      .wr_hi    (cyc_wr_hi),
      .wdata_lo (wval64[31:0]),
      .wdata_hi (wdata_hi),
      .count    (mcycle)
   );

   riscv_csr_counter u_minstret (
      .clk      (clk),
      .rstn     (rstn),
      .inc      (wb_retire),
      .wr_lo    (ins_wr_lo),
      .wr_hi    (ins_wr_hi),
      .wdata_lo (wval64[31:0]),
      .wdata_hi (wdata_hi),
      .count    (minstret)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         mie      <= 1'b0;
         mpie     <= 1'b0;
         mtvec    <= MTVEC_RESET;
         mscratch <= '0;
         mepc     <= '0;
         mcause   <= '0;
         mtval    <= '0;
      end else if (exc_take) begin
         mepc   <= ex_pc & EPC_MASK;
         mcause <= ex_cause;
         mtval  <= ex_tval;
         mpie   <= mie;
         mie    <= 1'b0;
      end else if (mret_take) begin
         mie  <= mpie;
         mpie <= 1'b1;
      end else if (csr_wen) begin
         case (ex_csr_reg)
            CSR_MSTATUS: begin
               mie  <= ex_csr_wval[MSTATUS_MIE];
               mpie <= ex_csr_wval[MSTATUS_MPIE];
            end
            CSR_MTVEC:    mtvec    <= ex_csr_wval & MTVEC_MASK;
            CSR_MSCRATCH: mscratch <= ex_csr_wval;
            CSR_MEPC:     mepc     <= ex_csr_wval & EPC_MASK;
            CSR_MCAUSE:   mcause   <= ex_csr_wval;
            CSR_MTVAL:    mtval    <= ex_csr_wval;
            default: ;
         endcase
      end
   end

   assign st_mtvec = mtvec;
   assign st_mepc  = mepc;
   assign st_mie   = mie;
   assign st_xlen  = (XLEN == 64) ? XLEN_RV64I : XLEN_RV32I;

endmodule

// File: tb/tb_riscv_csr_state.sv
// Directed bench for riscv_csr_state (XLEN=64, HAS_RVC=1): expected read data
// is queued when a read is driven and popped when the read port is sampled.
module tb_riscv_csr_state;

   logic        clk = 1'b0;
   logic        rstn;
   logic        ex_stall;
   logic [11:0] ex_csr_reg;
   logic        ex_csr_we;
   logic [63:0] ex_csr_wval;
   logic [63:0] st_csr_rval;
   logic        st_csr_illegal;
   logic [1:0]  st_xlen;
   logic        wb_retire;
   logic        ex_exception;
   logic [63:0] ex_cause, ex_pc, ex_tval;
   logic        ex_mret;
   logic [63:0] st_mtvec, st_mepc;
   logic        st_mie;

   int          checks   = 0;
   int          failures = 0;
   logic [63:0] cyc_exp;
   logic [63:0] sb_q[$];
   string       tag_q[$];

   riscv_csr_state dut (
      .clk            (clk),
      .rstn           (rstn),
      .ex_stall       (ex_stall),
      .ex_csr_reg     (ex_csr_reg),
      .ex_csr_we      (ex_csr_we),
      .ex_csr_wval    (ex_csr_wval),
      .st_csr_rval    (st_csr_rval),
      .st_csr_illegal (st_csr_illegal),
      .st_xlen        (st_xlen),
      .wb_retire      (wb_retire),
      .ex_exception   (ex_exception),
      .ex_cause       (ex_cause),
      .ex_pc          (ex_pc),
      .ex_tval        (ex_tval),
      .ex_mret        (ex_mret),
      .st_mtvec       (st_mtvec),
      .st_mepc        (st_mepc),
      .st_mie         (st_mie)
   );

   always #50 clk = ~clk;

   task automatic idle();
      ex_stall     = 1'b0;
      ex_csr_we    = 1'b0;
      ex_csr_wval  = '0;
      wb_retire    = 1'b0;
      ex_exception = 1'b0;
      ex_cause     = '0;
      ex_pc        = '0;
      ex_tval      = '0;
      ex_mret      = 1'b0;
   endtask

   // Advance one clock; inputs are driven on the falling edge.
   task automatic cyc();
      @(negedge clk);
      cyc_exp = cyc_exp + 64'd1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rd(input string tag, input logic [11:0] addr, input logic [63:0] exp);
      logic [63:0] e;
      string       t;
      ex_csr_reg = addr;
      sb_q.push_back(exp);
      tag_q.push_back(tag);
      #1;
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      check(t, st_csr_rval, e);
   endtask

   task automatic wr(input logic [11:0] addr, input logic [63:0] val);
      ex_csr_reg  = addr;
      ex_csr_we   = 1'b1;
      ex_csr_wval = val;
   endtask

   initial begin
      idle();
      ex_csr_reg = '0;
      rstn       = 1'b0;
      cyc_exp    = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn    = 1'b1;
      cyc_exp = '0;

      rd("rst_mtvec", 12'h305, 64'h100);
      rd("rst_mstatus", 12'h300, 64'h1800);
      check("rst_illegal", {63'd0, st_csr_illegal}, 64'd0);
      check("rst_xlen", {62'd0, st_xlen}, 64'd2);
      check("rst_st_mtvec", st_mtvec, 64'h100);
      check("rst_st_mepc", st_mepc, 64'd0);
      check("rst_st_mie", {63'd0, st_mie}, 64'd0);
      rd("rst_misa", 12'h301, 64'h8000_0000_0000_0104);
      rd("rst_mhartid", 12'hF14, 64'd0);
      repeat (5) cyc();
      rd("mcycle_5", 12'hB00, 64'd5);

      // Stalled write is dropped, then the real write lands.
      ex_stall = 1'b1;
      wr(12'h340, 64'hDEAD_BEEF);
      cyc();
      idle();
      rd("mscratch_stall", 12'h340, 64'd0);
      wr(12'h340, 64'hDEAD_BEEF);
      cyc();
      idle();
      rd("mscratch_wr", 12'h340, 64'hDEAD_BEEF);

      wr(12'hC00, 64'h55);
      #1;
      check("illegal_wr_c00", {63'd0, st_csr_illegal}, 64'd1);
      cyc();
      idle();
      rd("cycle_after_illegal", 12'hC00, cyc_exp);
      check("cycle_rd_legal", {63'd0, st_csr_illegal}, 64'd0);
      rd("unimpl_7c0", 12'h7C0, 64'd0);
      check("illegal_rd_7c0", {63'd0, st_csr_illegal}, 64'd1);

      wr(12'h305, 64'h203);
      cyc();
      idle();
      rd("mtvec_align", 12'h305, 64'h200);
      check("st_mtvec_wr", st_mtvec, 64'h200);
      wr(12'h341, 64'h7);
      cyc();
      idle();
      rd("mepc_align", 12'h341, 64'h6);

      wr(12'h300, 64'h8);
      cyc();
      idle();
      rd("mstatus_mie", 12'h300, 64'h1808);
      check("st_mie_set", {63'd0, st_mie}, 64'd1);

      // Exception with a simultaneous mscratch write: the write loses.
      wr(12'h340, 64'h1111);
      ex_exception = 1'b1;
      ex_pc        = 64'h2003;
      ex_cause     = 64'd2;
      ex_tval      = 64'h13;
      cyc();
      idle();
      check("st_mepc_trap", st_mepc, 64'h2002);
      rd("mepc_trap", 12'h341, 64'h2002);
      rd("mcause_trap", 12'h342, 64'd2);
      rd("mtval_trap", 12'h343, 64'h13);
      check("st_mie_trap", {63'd0, st_mie}, 64'd0);
      rd("mstatus_trap", 12'h300, 64'h1880);
      rd("mscratch_kept", 12'h340, 64'hDEAD_BEEF);

      // mret beats a same-cycle mscratch write.
      wr(12'h340, 64'h2222);
      ex_mret = 1'b1;
      cyc();
      idle();
      check("st_mie_mret", {63'd0, st_mie}, 64'd1);
      rd("mstatus_mret", 12'h300, 64'h1888);
      rd("mscratch_mret", 12'h340, 64'hDEAD_BEEF);

      wr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
      cyc();
      idle();
      cyc_exp = 64'hFFFF_FFFF_FFFF_FFFF;
      rd("mcycle_max", 12'hB00, cyc_exp);
      cyc();
      rd("mcycle_wrap", 12'hB00, cyc_exp);
      rd("cycle_shadow", 12'hC00, 64'd0);

      wr(12'hB02, 64'd10);
      wb_retire = 1'b1;
      cyc();
      idle();
      rd("minstret_wr", 12'hB02, 64'd10);
      wb_retire = 1'b1;
      repeat (3) cyc();
      wb_retire = 1'b0;
      cyc();
      rd("instret_inc", 12'hC02, 64'd13);
      rd("mcycleh_unimpl", 12'hB80, 64'd0);
      check("mcycleh_illegal", {63'd0, st_csr_illegal}, 64'd1);

      // Reset in the same cycle as a write aborts the write.
      wr(12'h340, 64'h777);
      rstn = 1'b0;
      cyc();
      idle();
      rstn    = 1'b1;
      cyc_exp = '0;
      rd("rst2_mscratch", 12'h340, 64'd0);
      rd("rst2_mcycle", 12'hB00, cyc_exp);
      rd("rst2_mtvec", 12'h305, 64'h100);
      rd("rst2_minstret", 12'hB02, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
